// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a single-port, registered-read DataMemory.
// Optional: define DMARB_RANGE_CHK_EN to reject addresses >= DEPTH with an Err completion.
module data_mem_arbiter #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req0,
  input  logic              i_req1,
  input  logic              i_wr0,
  input  logic              i_wr1,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata0,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_gnt0,
  output logic              o_gnt1,
  output logic              o_done0,
  output logic              o_done1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic              o_err0,
  output logic              o_err1,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic [DATA_W-1:0] o_mem_write_data,
  output logic              o_mem_read,
  output logic              o_mem_write,
  input  logic [DATA_W-1:0] i_mem_read_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t              r_state, w_state_next;
  logic                r_sel, w_sel_next;
  logic                r_last_gnt, w_last_gnt_next;
  logic                r_wr, w_wr_next;
  logic                r_oor, w_oor_next;
  logic [1:0]          r_gnt, w_gnt_next;
  logic [1:0]          r_done, w_done_next;
  logic [1:0]          r_err, w_err_next;
  logic [DATA_W-1:0]   r_rdata [2];
  logic [DATA_W-1:0]   w_rdata_next [2];
  logic [ADDR_W-1:0]   r_mem_address, w_mem_address_next;
  logic [DATA_W-1:0]   r_mem_write_data, w_mem_write_data_next;
  logic                r_mem_read, w_mem_read_next;
  logic                r_mem_write, w_mem_write_next;

  logic [1:0]          w_req;
  logic [1:0]          w_wr;
  logic [ADDR_W-1:0]   w_addr [2];
  logic [DATA_W-1:0]   w_wdata [2];
  logic                w_pick;
  logic                w_pick_oor;

  assign w_req      = {i_req1, i_req0};
  assign w_wr       = {i_wr1, i_wr0};
  assign w_addr[0]  = i_addr0;
  assign w_addr[1]  = i_addr1;
  assign w_wdata[0] = i_wdata0;
  assign w_wdata[1] = i_wdata1;

  // On a tie the port that did not win last time goes; otherwise the sole requester.
  assign w_pick = (i_req0 && i_req1) ? ~r_last_gnt : i_req1;

`ifdef DMARB_RANGE_CHK_EN
  assign w_pick_oor = (w_addr[w_pick] >= ADDR_W'(DEPTH));
`else
  assign w_pick_oor = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_sel            <= 1'b0;
      r_last_gnt       <= 1'b1;
      r_wr             <= 1'b0;
      r_oor            <= 1'b0;
      r_gnt            <= '0;
      r_done           <= '0;
      r_err            <= '0;
      r_rdata[0]       <= '0;
      r_rdata[1]       <= '0;
      r_mem_address    <= '0;
      r_mem_write_data <= '0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
    end else begin
      r_state          <= w_state_next;
      r_sel            <= w_sel_next;
      r_last_gnt       <= w_last_gnt_next;
      r_wr             <= w_wr_next;
      r_oor            <= w_oor_next;
      r_gnt            <= w_gnt_next;
      r_done           <= w_done_next;
      r_err            <= w_err_next;
      r_rdata[0]       <= w_rdata_next[0];
      r_rdata[1]       <= w_rdata_next[1];
      r_mem_address    <= w_mem_address_next;
      r_mem_write_data <= w_mem_write_data_next;
      r_mem_read       <= w_mem_read_next;
      r_mem_write      <= w_mem_write_next;
    end
  end

  // Outputs are computed one state ahead so every output comes straight from a flop.
  always_comb begin
    w_state_next          = r_state;
    w_sel_next            = r_sel;
    w_last_gnt_next       = r_last_gnt;
    w_wr_next             = r_wr;
    w_oor_next            = r_oor;
    w_gnt_next            = '0;
    w_done_next           = '0;
    w_err_next            = '0;
    w_rdata_next[0]       = r_rdata[0];
    w_rdata_next[1]       = r_rdata[1];
    w_mem_address_next    = '0;
    w_mem_write_data_next = '0;
    w_mem_read_next       = 1'b0;
    w_mem_write_next      = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          w_state_next          = S_ISSUE;
          w_sel_next            = w_pick;
          w_last_gnt_next       = w_pick;
          w_wr_next             = w_wr[w_pick];
          w_oor_next            = w_pick_oor;
          w_gnt_next[w_pick]    = 1'b1;
          w_mem_address_next    = w_addr[w_pick];
          w_mem_write_data_next = w_wdata[w_pick];
          w_mem_read_next       = ~w_wr[w_pick] & ~w_pick_oor;
          w_mem_write_next      = w_wr[w_pick] & ~w_pick_oor;
        end
      end
      S_ISSUE: begin
        if (r_wr || r_oor) begin
          w_state_next       = S_DONE;
          w_done_next[r_sel] = 1'b1;
          w_err_next[r_sel]  = r_oor;
          if (r_oor) begin
            w_rdata_next[r_sel] = '0;
          end
        end else begin
          w_state_next          = S_WAIT;
          w_mem_address_next    = r_mem_address;
          w_mem_write_data_next = r_mem_write_data;
        end
      end
      S_WAIT: begin
        // Memory read data is valid during this cycle; it lands in RData together with Done.
        w_state_next        = S_DONE;
        w_done_next[r_sel]  = 1'b1;
        w_rdata_next[r_sel] = i_mem_read_data;
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign o_gnt0           = r_gnt[0];
  assign o_gnt1           = r_gnt[1];
  assign o_done0          = r_done[0];
  assign o_done1          = r_done[1];
  assign o_err0           = r_err[0];
  assign o_err1           = r_err[1];
  assign o_rdata0         = r_rdata[0];
  assign o_rdata1         = r_rdata[1];
  assign o_mem_address    = r_mem_address;
  assign o_mem_write_data = r_mem_write_data;
  assign o_mem_read       = r_mem_read;
  assign o_mem_write      = r_mem_write;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: behavioural DataMemory, completion scoreboard
// and per-scenario timing checks.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_address, mem_wdata, mem_rd_data;
  logic        mem_read, mem_write;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          port;
    logic [31:0] r0;
    logic [31:0] r1;
    bit          err;
  } sb_t;

  sb_t         sb[$];
  logic [31:0] shadow [64];
  logic [31:0] exp_r [2];
  bit          exp_last;

  logic [31:0] mem [64];
  bit          mem_loaded = 1'b0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.DEPTH(32), .DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req0(req0), .i_req1(req1), .i_wr0(wr0), .i_wr1(wr1),
    .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_gnt0(gnt0), .o_gnt1(gnt1), .o_done0(done0), .o_done1(done1),
    .o_rdata0(rdata0), .o_rdata1(rdata1), .o_err0(err0), .o_err1(err1),
    .o_mem_address(mem_address), .o_mem_write_data(mem_wdata),
    .o_mem_read(mem_read), .o_mem_write(mem_write),
    .i_mem_read_data(mem_rd_data)
  );

  // DataMemory stand-in: registered read, one-cycle write, 64 words so stray addresses stay harmless
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      mem_loaded <= 1'b1;
      mem_rd_data <= '0;
    end else begin
      if (mem_read) mem_rd_data <= mem[mem_address[5:0]];
      if (mem_write) mem[mem_address[5:0]] <= mem_wdata;
    end
  end

  // Completion monitor: every Done must match the oldest scoreboard entry
  always @(negedge clk) begin
    sb_t e;
    if (rst_n) begin
      vectors++;
      if ((gnt0 && gnt1) || (mem_read && mem_write)) begin
        miscompares++;
        $display("FAIL exclusive_strobes got gnt=%b%b rd/wr=%b%b want at most one of each", gnt1, gnt0, mem_read, mem_write);
      end
      if (done0 || done1) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done got done=%b%b want none", done1, done0);
        end else begin
          e = sb.pop_front();
          if ((done0 && done1) || (done1 !== e.port) || (rdata0 !== e.r0) || (rdata1 !== e.r1) ||
              ({err1, err0} !== (e.port ? {e.err, 1'b0} : {1'b0, e.err}))) begin
            miscompares++;
            $display("FAIL done_payload got done=%b%b r0=%h r1=%h err=%b%b want port=%0d r0=%h r1=%h err=%b",
                     done1, done0, rdata0, rdata1, err1, err0, e.port, e.r0, e.r1, e.err);
          end
        end
      end
    end
  end

  task automatic push_expect(input bit port, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    sb_t e;
    bit  oor;
`ifdef DMARB_RANGE_CHK_EN
    oor = (addr >= 32);
`else
    oor = 1'b0;
`endif
    if (oor) exp_r[port] = '0;
    else if (wr) shadow[addr[5:0]] = wd;
    else exp_r[port] = shadow[addr[5:0]];
    e.port = port; e.r0 = exp_r[0]; e.r1 = exp_r[1]; e.err = oor;
    sb.push_back(e);
  endtask

  task automatic drive(input bit port, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    if (port) begin req1 = 1'b1; wr1 = wr; addr1 = addr; wdata1 = wd; end
    else begin req0 = 1'b1; wr0 = wr; addr0 = addr; wdata0 = wd; end
  endtask

  task automatic wait_gnt(input bit port, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ((port ? gnt1 : gnt0) === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_sb_empty(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (sb.size() == 0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic do_single(input bit port, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                           output bit ok);
    bit g, d;
    @(negedge clk);
    push_expect(port, wr, addr, wd);
    drive(port, wr, addr, wd);
    wait_gnt(port, g);
    if (port) req1 = 1'b0; else req0 = 1'b0;
    exp_last = port;
    wait_sb_empty(d);
    ok = g & d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1, mem_address, mem_wdata, mem_read, mem_write} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got gnt=%b%b done=%b%b r0=%h r1=%h addr=%h rd=%b wr=%b want all 0",
               gnt1, gnt0, done1, done0, rdata0, rdata1, mem_address, mem_read, mem_write);
    end
    rst_n = 1'b1;
    exp_r[0] = '0; exp_r[1] = '0; exp_last = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({gnt0, gnt1, done0, done1, mem_read, mem_write} !== '0) begin
      miscompares++;
      $display("FAIL idle_quiet got gnt=%b%b done=%b%b rd=%b wr=%b want 0", gnt1, gnt0, done1, done0, mem_read, mem_write);
    end
  endtask

  task automatic test_write_read();
    @(negedge clk);
    push_expect(0, 1, 5, 32'hDEAD_BEEF);
    drive(0, 1, 5, 32'hDEAD_BEEF);
    @(negedge clk);
    vectors++;
    if (gnt0 !== 1'b1 || mem_write !== 1'b1 || mem_read !== 1'b0 || mem_address !== 32'd5 || mem_wdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL write_issue got gnt0=%b wr=%b rd=%b addr=%h wd=%h want 1 1 0 5 deadbeef",
               gnt0, mem_write, mem_read, mem_address, mem_wdata);
    end
    req0 = 1'b0; exp_last = 1'b0;
    @(negedge clk);
    vectors++;
    if (done0 !== 1'b1 || gnt0 !== 1'b0 || mem_write !== 1'b0) begin
      miscompares++;
      $display("FAIL write_done got done0=%b gnt0=%b wr=%b want 1 0 0", done0, gnt0, mem_write);
    end
    @(negedge clk);
    push_expect(0, 0, 5, 32'h0);
    drive(0, 0, 5, 32'h0);
    @(negedge clk);
    vectors++;
    if (gnt0 !== 1'b1 || mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'd5) begin
      miscompares++;
      $display("FAIL read_issue got gnt0=%b rd=%b wr=%b addr=%h want 1 1 0 5", gnt0, mem_read, mem_write, mem_address);
    end
    req0 = 1'b0;
    @(negedge clk);
    vectors++;
    if (done0 !== 1'b0 || mem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL read_wait got done0=%b rd=%b want 0 0", done0, mem_read);
    end
    @(negedge clk);
    vectors++;
    if (done0 !== 1'b1 || rdata0 !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL read_done got done0=%b rdata0=%h want 1 deadbeef", done0, rdata0);
    end
  endtask

  task automatic test_rdata_hold();
    bit ok;
    do_single(0, 1, 9, 32'h0000_1234, ok);
    if (ok) do_single(0, 0, 9, 32'h0, ok);
    if (ok) do_single(1, 0, 2, 32'h0, ok);
    vectors++;
    if (!ok || rdata0 !== 32'h0000_1234 || rdata1 !== 32'h1000_0002) begin
      miscompares++;
      $display("FAIL rdata_hold got ok=%b r0=%h r1=%h want 1 00001234 10000002", ok, rdata0, rdata1);
    end
  endtask

  task automatic test_round_robin();
    bit exp_p, got, ok;
    int n = 0;
    @(negedge clk);
    exp_p = ~exp_last;
    for (int k = 0; k < 4; k++) begin
      push_expect(exp_p, 0, exp_p ? 32'd2 : 32'd1, 32'h0);
      exp_p = ~exp_p;
    end
    exp_p = ~exp_last;
    drive(0, 0, 1, 32'h0);
    drive(1, 0, 2, 32'h0);
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        got = gnt1;
        vectors++;
        if (got !== exp_p) begin
          miscompares++;
          $display("FAIL rr_order grant %0d got port %0d want port %0d", n, got, exp_p);
        end
        exp_last = got;
        exp_p = ~got;
        n++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    wait_sb_empty(ok);
    vectors++;
    if (n != 4 || !ok) begin
      miscompares++;
      $display("FAIL rr_timeout got grants=%0d drained=%b want 4 1", n, ok);
    end
  endtask

  task automatic test_reset_mid();
    bit g0, g1, ok;
    @(negedge clk);
    drive(0, 0, 3, 32'h0);
    drive(1, 0, 4, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1, mem_address, mem_wdata, mem_read, mem_write} !== '0) begin
      miscompares++;
      $display("FAIL async_reset got gnt=%b%b done=%b%b r0=%h r1=%h addr=%h rd=%b want all 0",
               gnt1, gnt0, done1, done0, rdata0, rdata1, mem_address, mem_read);
    end
    exp_r[0] = '0; exp_r[1] = '0; exp_last = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (done0 !== 1'b0 || done1 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_no_done got done=%b%b want 00", done1, done0);
    end
    rst_n = 1'b1;
    push_expect(0, 0, 3, 32'h0);
    push_expect(1, 0, 4, 32'h0);
    wait_gnt(0, g0);
    req0 = 1'b0;
    wait_gnt(1, g1);
    req1 = 1'b0;
    exp_last = 1'b1;
    wait_sb_energy_guard: begin
      wait_sb_empty(ok);
    end
    vectors++;
    if (!g0 || !g1 || !ok) begin
      miscompares++;
      $display("FAIL regrant_after_reset got g0=%b g1=%b drained=%b want 1 1 1", g0, g1, ok);
    end
  endtask

  task automatic test_range();
    bit ok;
    @(negedge clk);
    push_expect(1, 0, 40, 32'h0);
    drive(1, 0, 40, 32'h0);
    @(negedge clk);
    vectors++;
`ifdef DMARB_RANGE_CHK_EN
    if (gnt1 !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      miscompares++;
      $display("FAIL range_issue got gnt1=%b rd=%b wr=%b want 1 0 0", gnt1, mem_read, mem_write);
    end
`else
    if (gnt1 !== 1'b1 || mem_read !== 1'b1 || mem_address !== 32'd40) begin
      miscompares++;
      $display("FAIL range_issue got gnt1=%b rd=%b addr=%0d want 1 1 40", gnt1, mem_read, mem_address);
    end
`endif
    req1 = 1'b0; exp_last = 1'b1;
    @(negedge clk);
    vectors++;
`ifdef DMARB_RANGE_CHK_EN
    if (done1 !== 1'b1 || err1 !== 1'b1 || rdata1 !== 32'h0) begin
      miscompares++;
      $display("FAIL range_done got done1=%b err1=%b rdata1=%h want 1 1 0", done1, err1, rdata1);
    end
`else
    if (done1 !== 1'b0 || mem_read !== 1'b0) begin
      miscompares++;
      $display("FAIL range_wait got done1=%b rd=%b want 0 0", done1, mem_read);
    end
    @(negedge clk);
    vectors++;
    if (done1 !== 1'b1 || err1 !== 1'b0 || rdata1 !== 32'h1000_0028) begin
      miscompares++;
      $display("FAIL range_done got done1=%b err1=%b rdata1=%h want 1 0 10000028", done1, err1, rdata1);
    end
`endif
    wait_sb_empty(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL range_drain got pending=%0d want 0", sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) shadow[i] = 32'h1000_0000 + 32'(i);
    exp_r[0] = '0; exp_r[1] = '0; exp_last = 1'b1;
    test_reset();
    test_write_read();
    test_rdata_hold();
    test_round_robin();
    test_reset_mid();
    test_range();
    repeat (3) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expect got pending=%0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
